// File: rtl/chipper_ejector.sv
// chipper_ejector: ejection stage of a bufferless CHIPPER-style mesh router.
// Picks at most one flit per cycle addressed to this node out of the four
// incoming channels, queues it for the local core, and registers every other
// flit straight through. The ejected channel's slot is emptied for the injector.
module chipper_ejector #(
  parameter logic [2:0] NODE_ROW   = 3'd4,
  parameter logic [2:0] NODE_COL   = 3'd4,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    northad,
  input  logic [9:0]                    southad,
  input  logic [9:0]                    eastad,
  input  logic [9:0]                    westad,
  input  logic                          n_vld,
  input  logic                          s_vld,
  input  logic                          e_vld,
  input  logic                          w_vld,
  output logic [9:0]                    nad,
  output logic [9:0]                    sad,
  output logic [9:0]                    ead,
  output logic [9:0]                    wad,
  output logic                          nad_vld,
  output logic                          sad_vld,
  output logic                          ead_vld,
  output logic                          wad_vld,
  output logic [9:0]                    localad,
  output logic                          local_vld,
  input  logic                          local_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [CNT_W-1:0]              defl_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = CNT_W + 1;

  // Channel index order N=0, S=1, E=2, W=3 is also the round-robin order.
  logic [9:0]    in_flit [4];
  logic [3:0]    in_vld;
  logic [3:0]    cand;
  logic [3:0]    gold;
  logic [3:0]    pool;

  logic [1:0]    rr_ptr_reg, rr_ptr_next;
  logic [1:0]    win_idx, scan_idx;
  logic          win_found;
  logic          eligible, push, pop;
  logic [9:0]    win_flit;

  logic [2:0]    cand_num, losers;
  logic [DW-1:0] defl_sum;
  logic [CNT_W-1:0] defl_cnt_reg, defl_cnt_next;

  logic [9:0]    out_flit_reg [4];
  logic [3:0]    out_vld_reg;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] fifo_cnt_reg, fifo_cnt_next, remain;
  logic [9:0]    localad_reg, localad_next;
  logic          local_vld_reg;

  assign in_flit[0] = northad;
  assign in_flit[1] = southad;
  assign in_flit[2] = eastad;
  assign in_flit[3] = westad;
  assign in_vld     = {w_vld, e_vld, s_vld, n_vld};

  // An empty slot never matches, whatever its data bits hold.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_match
      assign cand[gi] = in_vld[gi] && (in_flit[gi][5:3] == NODE_ROW) &&
                        (in_flit[gi][2:0] == NODE_COL);
      assign gold[gi] = cand[gi] & in_flit[gi][9];
    end
  endgenerate

  // Golden candidates shadow the rest; the first pool member at or after the pointer wins.
  always_comb begin
    pool      = (|gold) ? gold : cand;
    win_found = 1'b0;
    win_idx   = rr_ptr_reg;
    scan_idx  = rr_ptr_reg;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr_reg + 2'(i);
      if (!win_found && pool[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Space is judged on the registered count, so a same-cycle pop never admits a push.
  assign eligible    = (fifo_cnt_reg < CW'(FIFO_DEPTH));
  assign push        = win_found & eligible;
  assign pop         = local_vld_reg & local_rdy;
  assign win_flit    = in_flit[win_idx];
  assign rr_ptr_next = push ? (win_idx + 2'd1) : rr_ptr_reg;

  // Every matching flit that is not taken this cycle counts as a deflection.
  always_comb begin
    cand_num = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cand_num = cand_num + 3'(cand[i]);
    end
    losers        = cand_num - 3'(push);
    defl_sum      = {1'b0, defl_cnt_reg} + DW'(losers);
    defl_cnt_next = defl_sum[CNT_W] ? {CNT_W{1'b1}} : defl_sum[CNT_W-1:0];
  end

  // Next head flit: a push into an emptied queue surfaces directly, otherwise the
  // entry at the advanced read pointer; an empty queue keeps showing the last head.
  always_comb begin
    fifo_cnt_next = fifo_cnt_reg + CW'(push) - CW'(pop);
    remain        = fifo_cnt_reg - CW'(pop);
    wr_ptr_next   = wr_ptr_reg + AW'(push);
    rd_ptr_next   = rd_ptr_reg + AW'(pop);
    localad_next  = localad_reg;
    if (push && (remain == '0)) begin
      localad_next = win_flit;
    end else if (remain != '0) begin
      localad_next = mem[rd_ptr_next];
    end
  end

  // Queue storage, written only on an accepted ejection.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= win_flit;
    end
  end

  // Queue pointers, occupancy, head flit and arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_cnt_reg  <= '0;
      localad_reg   <= '0;
      local_vld_reg <= 1'b0;
      rr_ptr_reg    <= 2'd0;
      defl_cnt_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      fifo_cnt_reg  <= fifo_cnt_next;
      localad_reg   <= localad_next;
      local_vld_reg <= (fifo_cnt_next != '0);
      rr_ptr_reg    <= rr_ptr_next;
      defl_cnt_reg  <= defl_cnt_next;
    end
  end

  // Register every channel through unchanged, except the winner which becomes an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        out_flit_reg[i] <= '0;
      end
      out_vld_reg <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push && (win_idx == 2'(i))) begin
          out_flit_reg[i] <= '0;
          out_vld_reg[i]  <= 1'b0;
        end else begin
          out_flit_reg[i] <= in_flit[i];
          out_vld_reg[i]  <= in_vld[i];
        end
      end
    end
  end

  assign nad       = out_flit_reg[0];
  assign sad       = out_flit_reg[1];
  assign ead       = out_flit_reg[2];
  assign wad       = out_flit_reg[3];
  assign nad_vld   = out_vld_reg[0];
  assign sad_vld   = out_vld_reg[1];
  assign ead_vld   = out_vld_reg[2];
  assign wad_vld   = out_vld_reg[3];
  assign localad   = localad_reg;
  assign local_vld = local_vld_reg;
  assign fifo_cnt  = fifo_cnt_reg;
  assign defl_cnt  = defl_cnt_reg;

endmodule

// File: tb/tb_chipper_ejector.sv
// Directed bench for chipper_ejector with default parameters (node 4,4; depth 4).
module tb_chipper_ejector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] northad, southad, eastad, westad;
  logic       n_vld, s_vld, e_vld, w_vld;
  logic [9:0] nad, sad, ead, wad;
  logic       nad_vld, sad_vld, ead_vld, wad_vld;
  logic [9:0] localad;
  logic       local_vld;
  logic       local_rdy;
  logic [2:0] fifo_cnt;
  logic [7:0] defl_cnt;

  int tests  = 0;
  int failed = 0;

  chipper_ejector dut (
    .clk(clk), .rst_n(rst_n),
    .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
    .n_vld(n_vld), .s_vld(s_vld), .e_vld(e_vld), .w_vld(w_vld),
    .nad(nad), .sad(sad), .ead(ead), .wad(wad),
    .nad_vld(nad_vld), .sad_vld(sad_vld), .ead_vld(ead_vld), .wad_vld(wad_vld),
    .localad(localad), .local_vld(local_vld), .local_rdy(local_rdy),
    .fifo_cnt(fifo_cnt), .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    n_vld = 1'b0; s_vld = 1'b0; e_vld = 1'b0; w_vld = 1'b0;
  endtask

  logic [9:0] seq [6];
  int rcv;

  initial begin
    seq = '{10'h024, 10'h064, 10'h0A4, 10'h224, 10'h2E4, 10'h3E4};
    rst_n = 1'b0; local_rdy = 1'b0;
    northad = '0; southad = '0; eastad = '0; westad = '0;
    clear_in();
    tick(); tick();
    check("rst_local_vld", local_vld, 0);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_defl", defl_cnt, 0);
    check("rst_localad", localad, 0);
    check("rst_nad_vld", nad_vld, 0);
    rst_n = 1'b1;

    // Single ejection from north, other channels non-local.
    northad = 10'h024; n_vld = 1'b1;
    southad = 10'h011; s_vld = 1'b1;
    eastad  = 10'h012; e_vld = 1'b1;
    westad  = 10'h033; w_vld = 1'b1;
    tick();
    $display("[TB] single eject: nad_vld=%0d localad=%h cnt=%0d", nad_vld, localad, fifo_cnt);
    check("t2_nad_vld", nad_vld, 0);
    check("t2_nad", nad, 0);
    check("t2_sad", {sad_vld, sad}, {1'b1, 10'h011});
    check("t2_ead", {ead_vld, ead}, {1'b1, 10'h012});
    check("t2_wad", {wad_vld, wad}, {1'b1, 10'h033});
    check("t2_local_vld", local_vld, 1);
    check("t2_localad", localad, 10'h024);
    check("t2_fifo_cnt", fifo_cnt, 1);
    check("t2_defl", defl_cnt, 0);

    // Invalid channels with local data must not match; pop empties the queue.
    clear_in(); local_rdy = 1'b1;
    tick();
    $display("[TB] pop: local_vld=%0d localad=%h cnt=%0d", local_vld, localad, fifo_cnt);
    check("t2_pop_cnt", fifo_cnt, 0);
    check("t2_pop_vld", local_vld, 0);
    check("t2_pop_hold", localad, 10'h024);
    check("t2_nad_vld_idle", nad_vld, 0);
    local_rdy = 1'b0;

    // Golden east beats plain north.
    eastad = 10'h224; e_vld = 1'b1;
    northad = 10'h024; n_vld = 1'b1;
    tick();
    $display("[TB] golden: ead_vld=%0d nad=%h localad=%h defl=%0d", ead_vld, nad, localad, defl_cnt);
    check("t3_ead_vld", ead_vld, 0);
    check("t3_ead", ead, 0);
    check("t3_nad", {nad_vld, nad}, {1'b1, 10'h024});
    check("t3_localad", localad, 10'h224);
    check("t3_defl", defl_cnt, 1);
    clear_in(); local_rdy = 1'b1;
    tick();
    local_rdy = 1'b0;

    // Build occupancy 3, then reset mid-traffic.
    northad = 10'h064; n_vld = 1'b1; tick();
    northad = 10'h0A4; tick();
    northad = 10'h0E4; tick();
    $display("[TB] filled: cnt=%0d localad=%h", fifo_cnt, localad);
    check("t1_pre_cnt", fifo_cnt, 3);
    check("t1_pre_head", localad, 10'h064);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset: cnt=%0d local_vld=%0d defl=%0d", fifo_cnt, local_vld, defl_cnt);
    check("t1_cnt", fifo_cnt, 0);
    check("t1_local_vld", local_vld, 0);
    check("t1_defl", defl_cnt, 0);
    check("t1_nad_vld", nad_vld, 0);
    check("t1_nad", nad, 0);
    check("t1_localad", localad, 0);
    clear_in();
    #2 rst_n = 1'b1;

    // Round-robin between north and south starting from north.
    northad = 10'h124; n_vld = 1'b1;
    southad = 10'h164; s_vld = 1'b1;
    tick();
    $display("[TB] rr1: nad_vld=%0d sad_vld=%0d defl=%0d", nad_vld, sad_vld, defl_cnt);
    check("t4a_nad_vld", nad_vld, 0);
    check("t4a_sad", {sad_vld, sad}, {1'b1, 10'h164});
    check("t4a_defl", defl_cnt, 1);
    check("t4a_localad", localad, 10'h124);
    tick();
    $display("[TB] rr2: nad_vld=%0d sad_vld=%0d defl=%0d", nad_vld, sad_vld, defl_cnt);
    check("t4b_nad", {nad_vld, nad}, {1'b1, 10'h124});
    check("t4b_sad_vld", sad_vld, 0);
    check("t4b_defl", defl_cnt, 2);
    check("t4b_cnt", fifo_cnt, 2);
    clear_in();

    // Fill to depth, then a west local flit must be deflected.
    northad = 10'h1A4; n_vld = 1'b1; tick();
    northad = 10'h1E4; tick();
    check("t5_full_cnt", fifo_cnt, 4);
    clear_in();
    westad = 10'h0A4; w_vld = 1'b1;
    tick();
    $display("[TB] full: wad=%h wad_vld=%0d defl=%0d cnt=%0d", wad, wad_vld, defl_cnt, fifo_cnt);
    check("t5_wad", {wad_vld, wad}, {1'b1, 10'h0A4});
    check("t5_defl", defl_cnt, 3);
    check("t5_cnt_hold", fifo_cnt, 4);
    local_rdy = 1'b1;
    tick();
    $display("[TB] full+pop: wad_vld=%0d defl=%0d cnt=%0d localad=%h", wad_vld, defl_cnt, fifo_cnt, localad);
    check("t5p_wad", {wad_vld, wad}, {1'b1, 10'h0A4});
    check("t5p_defl", defl_cnt, 4);
    check("t5p_cnt", fifo_cnt, 3);
    check("t5p_localad", localad, 10'h164);
    clear_in();

    // Drain the remaining three entries in order.
    check("t6_drain0", localad, 10'h164); tick();
    check("t6_drain1", localad, 10'h1A4); tick();
    check("t6_drain2", localad, 10'h1E4); tick();
    check("t6_drained_vld", local_vld, 0);
    check("t6_drained_hold", localad, 10'h1E4);

    // Six pushes with the core ready only on odd cycles.
    rcv = 0;
    for (int k = 0; k < 20 && rcv < 6; k++) begin
      n_vld     = (k < 6);
      northad   = (k < 6) ? seq[k] : 10'h000;
      local_rdy = (k % 2 == 1);
      if (local_vld && local_rdy) begin
        $display("[TB] core recv %0d: localad=%h", rcv, localad);
        check("t6_recv", localad, seq[rcv]);
        rcv++;
      end
      tick();
    end
    clear_in(); local_rdy = 1'b0;
    check("t6_recv_count", rcv, 6);
    check("t6_final_cnt", fifo_cnt, 0);
    check("t6_final_defl", defl_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
